// File: rtl/lvds_rx_pkg.sv
// Shared types and helpers for the LVDS receive word aligner.
package lvds_rx_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        LOCKED = 2'd3
    } state_e;

    function automatic int off_width(input int factor);
        int w;
        w = $clog2(factor);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lvds_word_window.sv
// One channel of the aligner: keeps the previous word and picks the FACTOR-bit
// window {prev, curr}[FACTOR-1+offset -: FACTOR]; offset 0 passes curr through.
module lvds_word_window #(
    parameter int FACTOR = 6,
    parameter int OFF_W  = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [FACTOR-1:0] word_i,
    input  logic [OFF_W-1:0]  offset_i,
    output logic [FACTOR-1:0] window_o
);
    localparam int IDX_W = $clog2(2 * FACTOR);

    logic [FACTOR-1:0]   prev_q;
    logic [2*FACTOR-1:0] concat;
    logic [IDX_W-1:0]    base;

    always_ff @(posedge clk_i) begin
        if (rst_i) prev_q <= '0;
        else       prev_q <= word_i;
    end

    assign concat   = {prev_q, word_i};
    assign base     = IDX_W'(offset_i);
    assign window_o = concat[base +: FACTOR];

endmodule

// File: rtl/lvds_rx_word_aligner.sv
// Soft word aligner: searches the bit offset that reproduces FRAME_PATTERN on the
// frame channel, applies it to all data channels, tracks lock and realigns.
// Optional saturating relock counter: define LVDS_RX_RELOCK_COUNT_EN.
module lvds_rx_word_aligner
    import lvds_rx_pkg::*;
#(
    parameter int                FACTOR        = 6,
    parameter int                CHANNELS      = 4,
    parameter logic [FACTOR-1:0] FRAME_PATTERN = 6'b111000,
    parameter int                SETTLE_CYCLES = 4,
    parameter int                LOCK_COUNT    = 16,
    parameter int                ERR_LIMIT     = 4,
    localparam int               OFF_W         = off_width(FACTOR)
) (
    input  logic                       refclk,
    input  logic                       rst,
    input  logic                       pll_locked,
    input  logic                       realign,
    input  logic [FACTOR-1:0]          rx_frame,
    input  logic [CHANNELS*FACTOR-1:0] rx_data,
    output logic [CHANNELS*FACTOR-1:0] aligned_data,
    output logic                       aligned_valid,
    output logic                       locked,
    output logic [OFF_W-1:0]           offset,
    output logic                       align_err,
    output logic [7:0]                 relock_count
);
    localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
    localparam int MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int ERR_W   = $clog2(ERR_LIMIT + 1);

    logic                       pll_s1_q, pll_s2_q;
    state_e                     state_q, state_d;
    logic [OFF_W-1:0]           offset_q, offset_d, offset_next;
    logic [SET_W-1:0]           settle_q, settle_d;
    logic [MATCH_W-1:0]         match_q, match_d;
    logic [ERR_W-1:0]           err_q, err_d;
    logic                       align_err_q, align_err_d;
    logic [FACTOR-1:0]          frame_win;
    logic [CHANNELS*FACTOR-1:0] data_win, aligned_q;
    logic                       frame_ok;

    lvds_word_window #(.FACTOR(FACTOR), .OFF_W(OFF_W)) u_frame_win (
        .clk_i    (refclk),
        .rst_i    (rst),
        .word_i   (rx_frame),
        .offset_i (offset_q),
        .window_o (frame_win)
    );

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        lvds_word_window #(.FACTOR(FACTOR), .OFF_W(OFF_W)) u_win (
            .clk_i    (refclk),
            .rst_i    (rst),
            .word_i   (rx_data[c*FACTOR +: FACTOR]),
            .offset_i (offset_q),
            .window_o (data_win[c*FACTOR +: FACTOR])
        );
    end

    assign frame_ok    = (frame_win == FRAME_PATTERN);
    assign offset_next = (offset_q == OFF_W'(FACTOR - 1)) ? '0 : offset_q + 1'b1;

    // Priority: PLL loss, then realign, then normal per-state handling.
    always_comb begin
        state_d     = state_q;
        offset_d    = offset_q;
        settle_d    = settle_q;
        match_d     = match_q;
        err_d       = err_q;
        align_err_d = 1'b0;
        if (!pll_s2_q) begin
            state_d  = IDLE;
            settle_d = '0;
            match_d  = '0;
            err_d    = '0;
        end else if (realign && state_q != IDLE) begin
            state_d  = SETTLE;
            settle_d = '0;
            match_d  = '0;
            err_d    = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d  = SETTLE;
                    settle_d = '0;
                end
                SETTLE: begin
                    if (settle_q == SET_W'(SETTLE_CYCLES - 1)) begin
                        state_d  = CHECK;
                        settle_d = '0;
                    end else begin
                        settle_d = settle_q + 1'b1;
                    end
                end
                CHECK: begin
                    if (!frame_ok) begin
                        match_d  = '0;
                        offset_d = offset_next;
                        settle_d = '0;
                        state_d  = SETTLE;
                    end else if (match_q == MATCH_W'(LOCK_COUNT - 1)) begin
                        match_d = '0;
                        err_d   = '0;
                        state_d = LOCKED;
                    end else begin
                        match_d = match_q + 1'b1;
                    end
                end
                LOCKED: begin
                    if (frame_ok) begin
                        err_d = '0;
                    end else if (err_q == ERR_W'(ERR_LIMIT - 1)) begin
                        align_err_d = 1'b1;
                        err_d       = '0;
                        offset_d    = offset_next;
                        settle_d    = '0;
                        state_d     = SETTLE;
                    end else begin
                        err_d = err_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            pll_s1_q    <= 1'b0;
            pll_s2_q    <= 1'b0;
            state_q     <= IDLE;
            offset_q    <= '0;
            settle_q    <= '0;
            match_q     <= '0;
            err_q       <= '0;
            align_err_q <= 1'b0;
            aligned_q   <= '0;
        end else begin
            pll_s1_q    <= pll_locked;
            pll_s2_q    <= pll_s1_q;
            state_q     <= state_d;
            offset_q    <= offset_d;
            settle_q    <= settle_d;
            match_q     <= match_d;
            err_q       <= err_d;
            align_err_q <= align_err_d;
            aligned_q   <= data_win;
        end
    end

    assign aligned_data  = aligned_q;
    assign aligned_valid = (state_q == LOCKED);
    assign locked        = (state_q == LOCKED);
    assign offset        = offset_q;
    assign align_err     = align_err_q;

`ifdef LVDS_RX_RELOCK_COUNT_EN
    logic [7:0] relock_q;

    always_ff @(posedge refclk) begin
        if (rst)                                  relock_q <= '0;
        else if (align_err_q && relock_q != 8'hFF) relock_q <= relock_q + 8'd1;
    end

    assign relock_count = relock_q;
`else
    assign relock_count = 8'd0;
`endif

endmodule

// File: tb/tb_lvds_rx_word_aligner.sv
// Randomized bench: a serial bitstream model produces the deserializer words for a
// given bit slip; the recovered words are the transmitted ones at offset == slip.
module tb_lvds_rx_word_aligner;
    localparam int F    = 6;
    localparam int CH   = 4;
    localparam int MAXW = 16384;
    localparam logic [F-1:0] PAT = 6'b111000;
    localparam int SETTLE = 4;
    localparam int LOCKN  = 16;
`ifdef LVDS_RX_RELOCK_COUNT_EN
    localparam int NEV = 300;
`else
    localparam int NEV = 5;
`endif

    logic          refclk = 1'b0;
    logic          rst, pll_locked, realign;
    logic [F-1:0]  rx_frame;
    logic [CH*F-1:0] rx_data, aligned_data;
    logic          aligned_valid, locked, align_err;
    logic [2:0]    offset;
    logic [7:0]    relock_count;

    logic [F-1:0] frame_w [MAXW];
    logic [F-1:0] data_w  [CH][MAXW];
    int idx, shift, checks, errors, err_pulses;
    bit relock_seen;

    lvds_rx_word_aligner #(
        .FACTOR(F), .CHANNELS(CH), .FRAME_PATTERN(PAT),
        .SETTLE_CYCLES(SETTLE), .LOCK_COUNT(LOCKN), .ERR_LIMIT(4)
    ) dut (
        .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .realign(realign),
        .rx_frame(rx_frame), .rx_data(rx_data), .aligned_data(aligned_data),
        .aligned_valid(aligned_valid), .locked(locked), .offset(offset),
        .align_err(align_err), .relock_count(relock_count)
    );

    always #5 refclk = ~refclk;

    // Bit at absolute stream position pos (MSB of each word is sent first).
    function automatic logic get_bit(input int ch, input int pos);
        logic [F-1:0] w;
        if (ch == CH) w = frame_w[pos / F];
        else          w = data_w[ch][pos / F];
        return w[F-1 - (pos % F)];
    endfunction

    // Deserializer word n when the word boundary slips s bits late.
    function automatic logic [F-1:0] rx_word(input int ch, input int n, input int s);
        logic [F-1:0] r;
        for (int i = 0; i < F; i++) r[F-1-i] = get_bit(ch, n*F + s + i);
        return r;
    endfunction

    function automatic logic [CH*F-1:0] exp_data(input int m);
        logic [CH*F-1:0] v;
        for (int c = 0; c < CH; c++) v[c*F +: F] = data_w[c][m];
        return v;
    endfunction

    task automatic drive();
        rx_frame = rx_word(CH, idx, shift);
        for (int c = 0; c < CH; c++) rx_data[c*F +: F] = rx_word(c, idx, shift);
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
        if (align_err === 1'b1) err_pulses++;
        if (relock_count !== 8'd0) relock_seen = 1'b1;
        if (idx >= MAXW - 3) begin
            $display("FAIL stimulus_table: idx=%0d exceeds table %0d", idx, MAXW);
            $fatal(1);
        end
        idx++;
        drive();
    endtask

    task automatic wait_locked(input logic lvl, input int bound, output bit ok);
        int n;
        n = 0;
        while (locked !== lvl && n < bound) begin
            step();
            n++;
        end
        ok = (locked === lvl);
    endtask

    task automatic test_reset();
        rst = 1'b1; pll_locked = 1'b0; realign = 1'b0; shift = 0;
        drive();
        repeat (3) step();
        checks++;
        if ({aligned_data, aligned_valid, locked, offset, align_err, relock_count} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: data=%h valid=%b locked=%b off=%0d err=%b rc=%0d, want all 0",
                     aligned_data, aligned_valid, locked, offset, align_err, relock_count);
        end
        rst = 1'b0;
        repeat (10) step();
        checks++;
        if (locked !== 1'b0 || offset !== 3'd0) begin
            errors++;
            $display("FAIL idle_no_pll: locked=%b off=%0d, want 0/0", locked, offset);
        end
    endtask

    task automatic test_lock_rot2();
        bit ok;
        shift = 2; err_pulses = 0; pll_locked = 1'b1;
        drive();
        wait_locked(1'b1, 400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rot2_lock: locked=%b, want 1", locked); end
        checks++;
        if (offset !== 3'd2) begin errors++; $display("FAIL rot2_offset: got %0d want 2", offset); end
        checks++;
        if (err_pulses != 0) begin errors++; $display("FAIL rot2_no_err: got %0d pulses want 0", err_pulses); end
        for (int i = 0; i < 16; i++) begin
            step();
            checks++;
            if (aligned_data !== exp_data(idx-1) || aligned_valid !== 1'b1) begin
                errors++;
                $display("FAIL rot2_data: got %h valid=%b want %h valid=1",
                         aligned_data, aligned_valid, exp_data(idx-1));
            end
        end
    endtask

    task automatic test_wrap();
        bit ok;
        rst = 1'b1; step(); step(); rst = 1'b0;
        shift = 5;
        wait_locked(1'b1, 400, ok);
        checks++;
        if (!ok || offset !== 3'd5) begin
            errors++;
            $display("FAIL rot5_lock: locked=%b off=%0d, want 1/5", locked, offset);
        end
        err_pulses = 0;
        shift = 0;
        wait_locked(1'b0, 20, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rot0_loss: locked=%b want 0", locked); end
        wait_locked(1'b1, 400, ok);
        repeat (4) step();
        checks++;
        if (!ok || offset !== 3'd0) begin
            errors++;
            $display("FAIL wrap_relock: locked=%b off=%0d, want 1/0", locked, offset);
        end
        checks++;
        if (err_pulses != 1) begin errors++; $display("FAIL wrap_err_pulse: got %0d want 1", err_pulses); end
        for (int i = 0; i < 8; i++) begin
            step();
            checks++;
            if (aligned_data !== exp_data(idx-1)) begin
                errors++;
                $display("FAIL wrap_data: got %h want %h", aligned_data, exp_data(idx-1));
            end
        end
    endtask

    task automatic test_bad_frames();
        bit dropped;
        dropped = 1'b0; err_pulses = 0;
        for (int b = 0; b < 2; b++) begin
            for (int k = 2; k < 5; k++) frame_w[idx + k] = ~PAT;
            repeat (12) begin
                step();
                if (locked !== 1'b1) dropped = 1'b1;
            end
        end
        checks++;
        if (dropped) begin errors++; $display("FAIL bad3_locked: lock dropped, want held 1"); end
        checks++;
        if (err_pulses != 0) begin errors++; $display("FAIL bad3_no_err: got %0d pulses want 0", err_pulses); end
    endtask

    task automatic test_realign();
        int cnt;
        cnt = 0; err_pulses = 0;
        realign = 1'b1;
        step();
        realign = 1'b0;
        while (locked === 1'b0 && cnt < 100) begin
            cnt++;
            step();
        end
        checks++;
        if (cnt != SETTLE + LOCKN || locked !== 1'b1) begin
            errors++;
            $display("FAIL realign_gap: low for %0d cycles locked=%b, want %0d then 1", cnt, locked, SETTLE + LOCKN);
        end
        checks++;
        if (err_pulses != 0 || offset !== 3'd0) begin
            errors++;
            $display("FAIL realign_quiet: pulses=%0d off=%0d, want 0/0", err_pulses, offset);
        end
    endtask

    task automatic test_pll_drop();
        bit ok, seen_hi, bad_off;
        shift = 3;
        wait_locked(1'b0, 20, ok);
        wait_locked(1'b1, 400, ok);
        checks++;
        if (!ok || offset !== 3'd3) begin
            errors++;
            $display("FAIL rot3_lock: locked=%b off=%0d, want 1/3", locked, offset);
        end
        realign = 1'b1; step(); realign = 1'b0;
        repeat (8) step();
        pll_locked = 1'b0;
        seen_hi = 1'b0;
        repeat (25) begin
            step();
            if (locked !== 1'b0) seen_hi = 1'b1;
        end
        checks++;
        if (seen_hi || offset !== 3'd3) begin
            errors++;
            $display("FAIL pll_drop_check: locked_seen=%b off=%0d, want 0/3", seen_hi, offset);
        end
        pll_locked = 1'b1;
        bad_off = 1'b0;
        for (int n = 0; n < 200 && locked !== 1'b1; n++) begin
            step();
            if (offset !== 3'd3) bad_off = 1'b1;
        end
        checks++;
        if (locked !== 1'b1 || bad_off) begin
            errors++;
            $display("FAIL pll_resume: locked=%b offset_moved=%b, want 1/0", locked, bad_off);
        end
        pll_locked = 1'b0;
        repeat (3) step();
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL pll_drop_locked: locked=%b want 0 within 3", locked); end
        pll_locked = 1'b1;
        wait_locked(1'b1, 200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL pll_relock: locked=%b want 1", locked); end
    endtask

    task automatic test_rst_mid_settle();
        bit ok;
        realign = 1'b1; step(); realign = 1'b0;
        step();
        rst = 1'b1;
        step();
        checks++;
        if ({aligned_data, aligned_valid, locked, offset, align_err, relock_count} !== '0) begin
            errors++;
            $display("FAIL rst_settle: data=%h valid=%b locked=%b off=%0d err=%b rc=%0d, want all 0",
                     aligned_data, aligned_valid, locked, offset, align_err, relock_count);
        end
        rst = 1'b0;
        wait_locked(1'b1, 400, ok);
        checks++;
        if (!ok || offset !== 3'd3) begin
            errors++;
            $display("FAIL rst_relock: locked=%b off=%0d, want 1/3", locked, offset);
        end
    endtask

    task automatic test_relock_count();
        bit ok, ok2;
        int ev;
        ev = 0; err_pulses = 0;
        for (int e = 0; e < NEV; e++) begin
            shift = (shift + 1) % F;
            wait_locked(1'b0, 20, ok);
            wait_locked(1'b1, 200, ok2);
            ev++;
            if (!ok || !ok2) begin
                checks++; errors++;
                $display("FAIL relock_event: event %0d locked=%b, want drop then relock", e, locked);
                break;
            end
`ifdef LVDS_RX_RELOCK_COUNT_EN
            if (ev == 100) begin
                checks++;
                if (relock_count !== 8'd100) begin
                    errors++;
                    $display("FAIL relock_mid: got %0d want 100", relock_count);
                end
            end
`endif
        end
        checks++;
        if (err_pulses != ev) begin errors++; $display("FAIL relock_pulses: got %0d want %0d", err_pulses, ev); end
        checks++;
`ifdef LVDS_RX_RELOCK_COUNT_EN
        if (relock_count !== ((ev > 255) ? 8'd255 : 8'(ev))) begin
            errors++;
            $display("FAIL relock_sat: got %0d want %0d", relock_count, (ev > 255) ? 255 : ev);
        end
`else
        if (relock_count !== 8'd0 || relock_seen) begin
            errors++;
            $display("FAIL relock_tied: got %0d seen_nonzero=%b want 0", relock_count, relock_seen);
        end
`endif
    endtask

    initial begin
        checks = 0; errors = 0; err_pulses = 0; idx = 1; relock_seen = 1'b0;
        for (int i = 0; i < MAXW; i++) begin
            frame_w[i] = PAT;
            for (int c = 0; c < CH; c++) data_w[c][i] = F'($urandom);
        end
        test_reset();
        test_lock_rot2();
        test_wrap();
        test_bad_frames();
        test_realign();
        test_pll_drop();
        test_rst_mid_settle();
        test_relock_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/lvds_rx_word_aligner.md
Name: lvds_rx_word_aligner

Overview:
- Parametrised soft word aligner for multi-channel LVDS receive. Sits in the core-clock domain, directly after the hard deserializers clocked by the x-FACTOR LVDS PLL.
- Finds the bit offset that reproduces the frame-channel pattern and applies that one offset to all data channels.
- Generalises the fixed x6 link to any factor and channel count. Adds lock tracking, loss-of-lock detection and automatic realignment.

Parameters:
- FACTOR, 6: deserialization factor, in bits per word per channel (valid range 3..10).
- CHANNELS, 4: number of data channels.
- FRAME_PATTERN, 6'b111000: expected frame word, FACTOR bits wide, MSB is the first bit received.
- SETTLE_CYCLES, 4: cycles to wait after an offset change before comparing.
- LOCK_COUNT, 16: consecutive matches required to declare lock.
- ERR_LIMIT, 4: consecutive mismatches while locked that declare loss of lock.

Ports:
- refclk, in, 1: core word clock (frame rate).
- rst, in, 1: synchronous reset, active-high.
- pll_locked, in, 1: PLL lock. Asynchronous source; double-registered inside the block.
- realign, in, 1: single-cycle request to force a fresh search.
- rx_frame, in, FACTOR: raw frame-channel word.
- rx_data, in, CHANNELS*FACTOR: raw data words; channel c occupies [c*FACTOR +: FACTOR].
- aligned_data, out, CHANNELS*FACTOR: data words with the selected offset applied.
- aligned_valid, out, 1: high when in LOCKED.
- locked, out, 1: alignment lock.
- offset, out, clog2(FACTOR): currently selected bit offset.
- align_err, out, 1: one-cycle pulse on each loss of lock.
- relock_count, out, 8: see Optional Feature.

Behaviour:
- Datapath:
  - Per channel, register the previous word: concat = {prev, curr}, 2*FACTOR bits.
  - Window at offset k is concat[FACTOR-1+k -: FACTOR]. k=0 selects curr.
  - The frame channel uses the identical window logic.
  - aligned_data is registered. The output at cycle n+1 uses the words that arrived at cycles n-1 and n. Latency is 1 cycle from the curr word.
- Reset: all outputs are 0, offset=0, state=IDLE, the sync registers and prev words are cleared.
- State machine:
  - IDLE: wait for synced pll_locked=1, then go to SETTLE.
  - SETTLE: count SETTLE_CYCLES, then go to CHECK.
  - CHECK:
    - If the frame window equals FRAME_PATTERN, increment the match counter. On reaching LOCK_COUNT, go to LOCKED.
    - On any mismatch, clear the match counter, set offset = (offset==FACTOR-1) ? 0 : offset+1, and go to SETTLE.
  - LOCKED:
    - locked=1 and aligned_valid=1.
    - A mismatch increments the error counter; a match clears it.
    - When the error counter reaches ERR_LIMIT: pulse align_err, clear locked, advance offset, go to SETTLE.
- Offset search wraps without limit; there is no fail state.
- realign in any state except IDLE: clear counters and locked, keep offset, go to SETTLE. align_err does not pulse.
- If pll_locked drops in any state: go to IDLE next cycle, locked=0, offset is kept. This has priority over realign and over mismatch handling.
- Same-cycle CHECK reaching the LOCK_COUNT-th match together with realign: realign wins.
- aligned_data keeps updating in every state; consumers must qualify it with aligned_valid.

Optional Feature:
- Macro: LVDS_RX_RELOCK_COUNT_EN.
- Defined: relock_count is an 8-bit saturating counter (stops at 255). It increments on each align_err pulse and is cleared only by rst.
- Undefined: relock_count is tied to 0 and no counter logic is built.

Decomposition:
- Package lvds_rx_pkg holds the state enum (IDLE, SETTLE, CHECK, LOCKED) and the function computing offset width as clog2(FACTOR), minimum 1.
- One sub-module, lvds_word_window: registers prev, selects the FACTOR-bit window for a given offset. It is instantiated CHANNELS+1 times.

Test Plan:
- Frame stream 111000 rotated by 2 bits, pll_locked=1 -> offset settles to 2; locked rises after LOCK_COUNT=16 matches; aligned_data equals the unrotated payload with 1-cycle latency.
- Rotation of 5 (offset 0→5, which tests wrap from 5 to 0 on a further rotation change) -> lock is reached at offset 5. Changing the rotation to 0 while locked produces 4 mismatches -> align_err pulses exactly once, search wraps from 5 to 0, lock returns.
- Inject 3 bad frame words while locked, then good words -> no align_err, locked stays 1, the error counter clears.
- Drop pll_locked mid-CHECK -> IDLE within 3 cycles (2-flop sync plus 1), locked=0; restore pll_locked -> search resumes from the kept offset.
- Pulse realign while locked with the correct offset -> locked=0 for SETTLE_CYCLES+LOCK_COUNT cycles, then 1 again; align_err stays 0. Pulse rst mid-SETTLE -> every output is 0 on the next cycle.
- With LVDS_RX_RELOCK_COUNT_EN defined: force 300 loss-of-lock events -> relock_count=255. Without the macro -> relock_count=0 throughout.
